// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   uart_tx_state_e : transmit FSM state encoding
//   UART_DATA_BITS  : data bits per frame
//   UART_IDLE_LVL   : serial line level when no frame is in flight
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte-write handshake into the UART transmit FIFO.
//   data_i  : byte to transmit (producer -> UART)
//   valid_i : data_i valid (producer -> UART)
//   ready_o : FIFO can accept a byte (UART -> producer)
// A byte transfers on a rising clock edge with valid_i & ready_o.
interface uart_tx_buffered_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data_i;
  logic                      valid_i;
  logic                      ready_o;

  modport master (output data_i, output valid_i, input ready_o);
  modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write strobe and data (ignored when full)
//   pop_i/data_o  : read strobe (ignored when empty) and head-of-queue data
//   full_o/empty_o: status derived from the registered count
//   count_o       : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read before it is written.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: TX FIFO feeding an 8N1 serialiser with
// optional even parity. Bytes go out LSB first.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wr_if (slave) : data_i/valid_i/ready_o byte-write handshake into the FIFO
//   div_i         : clocks per bit minus one, sampled when a frame starts
//   tx_o          : serial line, idle high, driven from a flop
//   busy_o        : frame in progress or FIFO non-empty
//   fifo_cnt_o    : FIFO occupancy
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  uart_tx_buffered_if.slave             wr_if,
  input  logic [DIV_W-1:0]              div_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  logic                      fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic [CW-1:0]             fifo_cnt;

  // ready depends only on the registered count, so a same-cycle pop
  // never lets a byte through a full FIFO.
  assign wr_if.ready_o = ~fifo_full;
  assign fifo_push     = wr_if.valid_i & ~fifo_full;

  uart_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (wr_if.data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  uart_tx_state_e            state_q, state_d;
  logic [DIV_W-1:0]          cnt_q, cnt_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      par_q, par_d;
  logic                      tx_q, tx_d;
  logic                      bit_end;

  assign bit_end = (cnt_q == '0);

  // tx_d is derived from the current state, so the line trails the FSM by
  // one clock; every bit period is shifted equally and widths are unchanged.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    par_d    = par_q;
    tx_d     = UART_IDLE_LVL;
    fifo_pop = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? div_q : cnt_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d = UART_IDLE_LVL;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          div_d    = div_i;
          cnt_d    = div_i;
          idx_d    = '0;
          par_d    = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        tx_d = par_q;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        tx_d = UART_IDLE_LVL;
        if (bit_end) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= UART_IDLE_LVL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o       = tx_q;
  assign busy_o     = (state_q != IDLE) | (fifo_cnt != '0);
  assign fifo_cnt_o = fifo_cnt;

endmodule

// File: tb/tb_uart_tx_buffered.sv
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;  // 50 MHz

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_buffered_if if0 ();
  uart_tx_buffered_if if1 ();

  logic [15:0] div0, div1;
  logic        tx0, tx1, busy0, busy1;
  logic [3:0]  cnt0, cnt1;

  uart_tx_buffered #(.FIFO_DEPTH(8), .PARITY_EN(0), .DIV_W(16)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .wr_if(if0), .div_i(div0),
    .tx_o(tx0), .busy_o(busy0), .fifo_cnt_o(cnt0));

  uart_tx_buffered #(.FIFO_DEPTH(8), .PARITY_EN(1), .DIV_W(16)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .wr_if(if1), .div_i(div1),
    .tx_o(tx1), .busy_o(busy1), .fifo_cnt_o(cnt1));

  typedef struct {
    logic [10:0] bits;
    int          nbits;
    int          period;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   starts0[$];
  int   starts1[$];
  int   checks = 0;
  int   fails = 0;
  int   aborted0 = 0;
  int   max_cnt0 = 0;
  bit   mon_busy0 = 1'b0;
  bit   mon_busy1 = 1'b0;

  always @(negedge clk) if (int'(cnt0) > max_cnt0) max_cnt0 <= int'(cnt0);

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input int per, input bit par_en, input bit par);
    exp_t e;
    e.bits      = '1;
    e.bits[0]   = 1'b0;
    e.bits[8:1] = d;
    if (par_en) begin
      e.bits[9] = par;
      e.nbits   = 11;
    end else begin
      e.nbits   = 10;
    end
    e.period = per;
    return e;
  endfunction

  // Line decoder: samples the first and last clock of every bit so the
  // bit period is checked exactly, not just at mid-bit.
  task automatic mon(input int inst);
    exp_t        e;
    logic [10:0] first, last;
    logic        v;
    bit          abort;
    int          t0, k;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (((inst == 0) ? tx0 : tx1) !== 1'b0) continue;
      t0 = cyc;
      if (inst == 0) starts0.push_back(t0); else starts1.push_back(t0);
      if (((inst == 0) ? sb0.size() : sb1.size()) == 0) begin
        chk($sformatf("unexpected frame inst%0d", inst), 1, 0);
        k = 0;
        while (((inst == 0) ? tx0 : tx1) !== 1'b1 && k < 10000) begin
          @(negedge clk); k++;
        end
        continue;
      end
      if (inst == 0) begin e = sb0.pop_front(); mon_busy0 = 1'b1; end
      else begin e = sb1.pop_front(); mon_busy1 = 1'b1; end
      first = '1;
      last  = '1;
      abort = 1'b0;
      for (int c = 0; c < e.nbits * e.period; c++) begin
        if (c > 0) @(negedge clk);
        if (!rst_n) begin abort = 1'b1; break; end
        v = (inst == 0) ? tx0 : tx1;
        if (c % e.period == 0) first[c / e.period] = v;
        if (c % e.period == e.period - 1) last[c / e.period] = v;
      end
      if (abort) begin
        if (inst == 0) aborted0++;
      end else begin
        chk($sformatf("frame bits (bit start) inst%0d @%0d", inst, t0), first, e.bits);
        chk($sformatf("frame bits (bit end) inst%0d @%0d", inst, t0), last, e.bits);
      end
      if (inst == 0) mon_busy0 = 1'b0; else mon_busy1 = 1'b0;
    end
  endtask

  task automatic push(input int inst, input logic [7:0] d, input int per,
                      input bit par_en, input bit par, output int seen, output int acc);
    int k;
    k = 0;
    if (inst == 0) begin if0.data_i = d; if0.valid_i = 1'b1; end
    else begin if1.data_i = d; if1.valid_i = 1'b1; end
    while (((inst == 0) ? if0.ready_o : if1.ready_o) !== 1'b1 && k < 20000) begin
      @(negedge clk); k++;
    end
    if (k >= 20000) chk("push ready timeout", 0, 1);
    seen = cyc;
    if (inst == 0) sb0.push_back(mk(d, per, par_en, par));
    else sb1.push_back(mk(d, per, par_en, par));
    @(negedge clk);
    acc = cyc;
    if (inst == 0) if0.valid_i = 1'b0; else if1.valid_i = 1'b0;
  endtask

  task automatic wait_drain(input int inst, input int budget);
    int k;
    k = 0;
    while (k < budget &&
           ((inst == 0) ? (sb0.size() != 0 || busy0 || mon_busy0)
                        : (sb1.size() != 0 || busy1 || mon_busy1))) begin
      @(negedge clk); k++;
    end
    chk($sformatf("drain within budget inst%0d", inst), (k < budget), 1);
  endtask

  task automatic wait_starts(input int inst, input int n, input int budget);
    int k;
    k = 0;
    while (((inst == 0) ? starts0.size() : starts1.size()) < n && k < budget) begin
      @(negedge clk); k++;
    end
    if (k >= budget) chk("start bit timeout", 0, 1);
  endtask

  function automatic int st0(input int i);
    return (i < starts0.size()) ? starts0[i] : -1;
  endfunction

  initial begin
    #1_800_000;
    $display("FAIL watchdog: run exceeded time limit (%0d checks, %0d failures so far)", checks, fails);
    $fatal(1, "watchdog");
  end

  logic [7:0] hello [6];
  logic [7:0] burst [10];

  initial begin
    int seen, acc, base, base1, target;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};
    burst = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C, 8'hC3};
    if0.valid_i = 1'b0; if0.data_i = '0;
    if1.valid_i = 1'b0; if1.data_i = '0;
    div0 = 16'd433;
    div1 = 16'd9;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx_o", tx0, 1);
    chk("reset ready_o", if0.ready_o, 1);
    chk("reset busy_o", busy0, 0);
    chk("reset fifo_cnt_o", cnt0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    fork
      mon(0);
      mon(1);
    join_none

    // 1: single byte, start-bit latency
    base = starts0.size();
    push(0, 8'h41, 434, 0, 0, seen, acc);
    wait_drain(0, 6000);
    chk("single byte start latency", st0(base), acc + 2);

    // 2: burst "Hello\n" back to back
    base = starts0.size();
    foreach (hello[i]) push(0, hello[i], 434, 0, 0, seen, acc);
    wait_drain(0, 30000);
    for (int i = 0; i < 5; i++)
      chk($sformatf("hello start spacing %0d", i), st0(base + i + 1) - st0(base + i), 4341);

    // 3: fill FIFO while transmitting
    div0 = 16'd9;
    base = starts0.size();
    push(0, burst[0], 10, 0, 0, seen, acc);
    wait_starts(0, base + 1, 100);
    for (int i = 1; i <= 8; i++) push(0, burst[i], 10, 0, 0, seen, acc);
    chk("full ready_o low", if0.ready_o, 0);
    chk("full fifo_cnt_o", cnt0, 8);
    push(0, burst[9], 10, 0, 0, seen, acc);
    chk("ready reassert cycle", seen, st0(base) + 100);
    wait_drain(0, 2000);
    chk("full start spacing", st0(base + 1) - st0(base), 101);
    chk("full frame count", starts0.size() - base, 10);

    // 4: even parity instance
    base1 = starts1.size();
    push(1, 8'h07, 10, 1, 1, seen, acc);
    push(1, 8'h03, 10, 1, 0, seen, acc);
    wait_drain(1, 1000);
    chk("parity start spacing", ((starts1.size() > base1 + 1) ? starts1[base1 + 1] - starts1[base1] : -1), 111);

    // 5: asynchronous reset during data bit 3
    base = starts0.size();
    push(0, 8'hA5, 10, 0, 0, seen, acc);
    wait_starts(0, base + 1, 100);
    target = st0(base) + 45;
    while (cyc < target) @(negedge clk);
    chk("tx before reset (A5 bit3)", tx0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-frame reset tx_o", tx0, 1);
    chk("mid-frame reset fifo_cnt_o", cnt0, 0);
    chk("mid-frame reset busy_o", busy0, 0);
    chk("mid-frame reset ready_o", if0.ready_o, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(0, 8'h5A, 10, 0, 0, seen, acc);
    wait_drain(0, 1000);
    chk("aborted frame count", aborted0, 1);

    // 6: divisor change mid-frame applies to the next frame only
    div0 = 16'd433;
    base = starts0.size();
    push(0, 8'h33, 434, 0, 0, seen, acc);
    wait_starts(0, base + 1, 50);
    repeat (20) @(negedge clk);
    div0 = 16'd216;
    push(0, 8'hCC, 217, 0, 0, seen, acc);
    wait_drain(0, 8000);
    chk("divisor change start spacing", st0(base + 1) - st0(base), 4341);

    chk("max fifo_cnt_o", max_cnt0, 8);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
